press_classifier: RTL and testbench

PRESS_CLASSIFIER -- requirements
Module: press_classifier

---
 rtl/press_classifier.sv | 139 +++++++++++++
 tb/tb_press_classifier.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/press_classifier.sv
// Button press classifier: turns a debounced button level into short, long and
// double-click pulses, plus a held level and a wrapping count of classified events.
`timescale 1ns/1ps

module press_classifier #(
  parameter int LONG_LIMIT = 25_000_000,
  parameter int DOUBLE_GAP = 6_250_000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_debounced,
  output logic       o_short_pulse,
  output logic       o_long_pulse,
  output logic       o_double_pulse,
  output logic       o_held,
  output logic [7:0] o_event_count
);

  localparam int CNT_MAX = (LONG_LIMIT > DOUBLE_GAP) ? LONG_LIMIT : DOUBLE_GAP;
  localparam int CNT_W   = $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_LIMIT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(DOUBLE_GAP - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_PRESS1    = 3'd1;
  localparam logic [2:0] S_WAIT_GAP  = 3'd2;
  localparam logic [2:0] S_PRESS2    = 3'd3;
  localparam logic [2:0] S_LONG_HOLD = 3'd4;

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic             r_prev;
  logic             rise;
  logic             short_nxt;
  logic             long_nxt;
  logic             double_nxt;
  logic             any_event;

  assign rise      = i_debounced & ~r_prev;
  assign any_event = short_nxt | long_nxt | double_nxt;
  assign o_held    = (state == S_LONG_HOLD);

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt  = state;
    count_nxt  = count;
    short_nxt  = 1'b0;
    long_nxt   = 1'b0;
    double_nxt = 1'b0;

    case (state)
      S_IDLE: begin
        if (rise) begin
          state_nxt = S_PRESS1;
          count_nxt = '0;
        end
      end

      S_PRESS1: begin
        if (i_debounced) begin
          if (count == LONG_LAST) begin
            state_nxt = S_LONG_HOLD;
            count_nxt = '0;
            long_nxt  = 1'b1;
          end else begin
            count_nxt = count + CNT_ONE;
          end
        end else begin
          state_nxt = S_WAIT_GAP;
          count_nxt = '0;
        end
      end

      // A press on the final gap cycle still counts as the second click.
      S_WAIT_GAP: begin
        if (i_debounced) begin
          state_nxt = S_PRESS2;
          count_nxt = '0;
        end else if (count == GAP_LAST) begin
          state_nxt = S_IDLE;
          count_nxt = '0;
          short_nxt = 1'b1;
        end else begin
          count_nxt = count + CNT_ONE;
        end
      end

      S_PRESS2: begin
        if (!i_debounced) begin
          state_nxt  = S_IDLE;
          count_nxt  = '0;
          double_nxt = 1'b1;
        end
      end

      S_LONG_HOLD: begin
        if (!i_debounced) begin
          state_nxt = S_IDLE;
          count_nxt = '0;
        end
      end

      default: begin
        state_nxt = S_IDLE;
        count_nxt = '0;
      end
    endcase
  end

  // NOTE: registers are updated with non-blocking assignments so every flop
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state          <= S_IDLE;
      count          <= '0;
      r_prev         <= 1'b1;
      o_short_pulse  <= 1'b0;
      o_long_pulse   <= 1'b0;
      o_double_pulse <= 1'b0;
      o_event_count  <= 8'd0;
    end else begin
      state          <= state_nxt;
      count          <= count_nxt;
      r_prev         <= i_debounced;
      o_short_pulse  <= short_nxt;
      o_long_pulse   <= long_nxt;
      o_double_pulse <= double_nxt;
      if (any_event) begin
        o_event_count <= o_event_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_press_classifier.sv
// Bench for press_classifier: per-cycle comparison against a run-length model of
// the button history, table-driven press patterns, and hand-written corner cases.
`timescale 1ns/1ps

module tb_press_classifier;

  localparam int LONG_LIMIT = 8;
  localparam int DOUBLE_GAP = 5;

  typedef struct {
    int hi1;
    int lo1;
    int hi2;
    int tail;
    int n_short;
    int n_long;
    int n_double;
  } vec_t;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       i_debounced;
  logic       o_short_pulse;
  logic       o_long_pulse;
  logic       o_double_pulse;
  logic       o_held;
  logic [7:0] o_event_count;

  press_classifier #(
    .LONG_LIMIT(LONG_LIMIT),
    .DOUBLE_GAP(DOUBLE_GAP)
  ) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_debounced   (i_debounced),
    .o_short_pulse (o_short_pulse),
    .o_long_pulse  (o_long_pulse),
    .o_double_pulse(o_double_pulse),
    .o_held        (o_held),
    .o_event_count (o_event_count)
  );

  always #5 i_clk = ~i_clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int seen_short  = 0;
  int seen_long   = 0;
  int seen_double = 0;
  int last_short_cyc = -1;
  int last_long_cyc  = -1;

  // Model: the current classification is kept as a list of alternating
  // high/low run lengths, starting with the first press.
  int unsigned runs[$];
  bit          long_fired;
  bit          m_prev;
  int          m_events;
  bit          e_short;
  bit          e_long;
  bit          e_double;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @cyc %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_step(input bit s, input bit rst);
    e_short  = 1'b0;
    e_long   = 1'b0;
    e_double = 1'b0;
    if (rst) begin
      runs.delete();
      long_fired = 1'b0;
      m_prev     = 1'b1;
      m_events   = 0;
    end else begin
      if (runs.size() == 0) begin
        if (s && !m_prev) runs.push_back(1);
      end else if (long_fired) begin
        if (!s) begin
          runs.delete();
          long_fired = 1'b0;
        end
      end else begin
        int k;
        bit last_high;
        k = runs.size() - 1;
        last_high = (runs.size() % 2) == 1;
        if (s == last_high) runs[k] = runs[k] + 1;
        else runs.push_back(1);
        // The rise sample itself is part of the first run, so the decisions
        // land on sample LIMIT+1 of the relevant run.
        case (runs.size())
          1: if (runs[0] == LONG_LIMIT + 1) begin
               e_long     = 1'b1;
               long_fired = 1'b1;
             end
          2: if (runs[1] == DOUBLE_GAP + 1) begin
               e_short = 1'b1;
               runs.delete();
             end
          4: begin
               e_double = 1'b1;
               runs.delete();
             end
          default: ;
        endcase
      end
      if (e_short || e_long || e_double) m_events = (m_events + 1) % 256;
      m_prev = s;
    end
  endtask

  task automatic step(input bit s);
    i_debounced = s;
    @(posedge i_clk);
    cyc++;
    model_step(s, i_rst);
    #1;
    check("short_pulse",  {31'd0, o_short_pulse},  {31'd0, e_short});
    check("long_pulse",   {31'd0, o_long_pulse},   {31'd0, e_long});
    check("double_pulse", {31'd0, o_double_pulse}, {31'd0, e_double});
    check("held",         {31'd0, o_held},         {31'd0, long_fired});
    check("event_count",  {24'd0, o_event_count},  m_events);
    if (o_short_pulse === 1'b1) begin
      seen_short++;
      last_short_cyc = cyc;
    end
    if (o_long_pulse === 1'b1) begin
      seen_long++;
      last_long_cyc = cyc;
    end
    if (o_double_pulse === 1'b1) seen_double++;
  endtask

  task automatic steps(input bit s, input int n);
    for (int i = 0; i < n; i++) step(s);
  endtask

  task automatic pulse_reset(input bit s);
    i_rst = 1'b1;
    step(s);
    i_rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[10];
    int b_s, b_l, b_d, rel, rise_cyc;
    bit lvl;

    vecs[0] = '{hi1: 3,  lo1: 0, hi2: 0,  tail: 10, n_short: 1, n_long: 0, n_double: 0};
    vecs[1] = '{hi1: 20, lo1: 0, hi2: 0,  tail: 10, n_short: 0, n_long: 1, n_double: 0};
    vecs[2] = '{hi1: 2,  lo1: 3, hi2: 2,  tail: 10, n_short: 0, n_long: 0, n_double: 1};
    vecs[3] = '{hi1: 2,  lo1: 5, hi2: 2,  tail: 10, n_short: 0, n_long: 0, n_double: 1};
    vecs[4] = '{hi1: 2,  lo1: 6, hi2: 2,  tail: 10, n_short: 2, n_long: 0, n_double: 0};
    vecs[5] = '{hi1: 8,  lo1: 0, hi2: 0,  tail: 10, n_short: 1, n_long: 0, n_double: 0};
    vecs[6] = '{hi1: 9,  lo1: 0, hi2: 0,  tail: 10, n_short: 0, n_long: 1, n_double: 0};
    vecs[7] = '{hi1: 1,  lo1: 0, hi2: 0,  tail: 10, n_short: 1, n_long: 0, n_double: 0};
    vecs[8] = '{hi1: 2,  lo1: 1, hi2: 30, tail: 10, n_short: 0, n_long: 0, n_double: 1};
    vecs[9] = '{hi1: 20, lo1: 2, hi2: 2,  tail: 10, n_short: 1, n_long: 1, n_double: 0};

    i_rst       = 1'b1;
    i_debounced = 1'b0;
    steps(1'b0, 3);
    check("rst_short",  {31'd0, o_short_pulse},  32'd0);
    check("rst_long",   {31'd0, o_long_pulse},   32'd0);
    check("rst_double", {31'd0, o_double_pulse}, 32'd0);
    check("rst_held",   {31'd0, o_held},         32'd0);
    check("rst_events", {24'd0, o_event_count},  32'd0);
    i_rst = 1'b0;
    steps(1'b0, 2);

    for (int i = 0; i < 10; i++) begin
      b_s = seen_short; b_l = seen_long; b_d = seen_double;
      steps(1'b1, vecs[i].hi1);
      steps(1'b0, vecs[i].lo1);
      steps(1'b1, vecs[i].hi2);
      steps(1'b0, vecs[i].tail);
      check($sformatf("vec%0d_short", i),  seen_short - b_s,  vecs[i].n_short);
      check($sformatf("vec%0d_long", i),   seen_long - b_l,   vecs[i].n_long);
      check($sformatf("vec%0d_double", i), seen_double - b_d, vecs[i].n_double);
    end

    // Short latency: pulse visible DOUBLE_GAP edges after the release edge.
    steps(1'b1, 3);
    rel = cyc + 1;
    steps(1'b0, 10);
    check("short_latency", last_short_cyc - rel, DOUBLE_GAP);

    // Long latency and held level.
    rise_cyc = cyc + 1;
    steps(1'b1, 20);
    check("long_latency", last_long_cyc - rise_cyc, LONG_LIMIT);
    check("held_while_pressed", {31'd0, o_held}, 32'd1);
    step(1'b0);
    check("held_after_release", {31'd0, o_held}, 32'd0);
    steps(1'b0, 8);

    // Button held through reset produces nothing until released and re-pressed.
    step(1'b1);
    i_rst = 1'b1;
    steps(1'b1, 2);
    i_rst = 1'b0;
    b_s = seen_short; b_l = seen_long; b_d = seen_double;
    steps(1'b1, 12);
    check("held_thru_rst_pulses", (seen_short - b_s) + (seen_long - b_l) + (seen_double - b_d), 0);
    check("held_thru_rst_events", {24'd0, o_event_count}, 32'd0);
    steps(1'b0, 3);
    steps(1'b1, 3);
    steps(1'b0, 10);
    check("repress_after_rst_short", seen_short - b_s, 1);

    // Reset during PRESS1 discards the pending event.
    pulse_reset(1'b0);
    steps(1'b0, 2);
    steps(1'b1, 4);
    pulse_reset(1'b1);
    b_s = seen_short; b_l = seen_long; b_d = seen_double;
    steps(1'b1, 3);
    steps(1'b0, 10);
    check("rst_mid_press_pulses", (seen_short - b_s) + (seen_long - b_l) + (seen_double - b_d), 0);
    check("rst_mid_press_events", {24'd0, o_event_count}, 32'd0);

    // 256 short presses wrap the event counter back to zero.
    b_s = seen_short;
    for (int i = 0; i < 256; i++) begin
      step(1'b1);
      steps(1'b0, DOUBLE_GAP + 1);
    end
    check("wrap_shorts", seen_short - b_s, 256);
    check("wrap_events", {24'd0, o_event_count}, 32'd0);

    // Random run lengths straddling both limits, with occasional resets.
    pulse_reset(1'b0);
    lvl = 1'b0;
    for (int r = 0; r < 500; r++) begin
      lvl = ~lvl;
      if ($urandom_range(0, 39) == 0) pulse_reset(lvl);
      steps(lvl, $urandom_range(1, 12));
    end
    steps(1'b0, 12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
